// File: rtl/diff_block_pipe_if.sv
// Handshake bundle for diff_block_pipe: pixel beats in, residual beats out.
// master = producer/consumer side (testbench), slave = the residual stage.
interface diff_block_pipe_if #(
    parameter int PIX_W = 8,
    parameter int LANES = 4,
    parameter int ROWS  = 4
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int SAD_W = PIX_W + $clog2(LANES * ROWS);

    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*PIX_W-1:0]       org;
    logic [LANES*PIX_W-1:0]       cur;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*(PIX_W+1)-1:0]   diff;
    logic [ROW_W-1:0]             out_row;
    logic                         out_last;
    logic [SAD_W-1:0]             sad;

    modport master (
        output in_valid, org, cur, out_ready,
        input  in_ready, out_valid, diff, out_row, out_last, sad
    );

    modport slave (
        input  in_valid, org, cur, out_ready,
        output in_ready, out_valid, diff, out_row, out_last, sad
    );
endinterface

// File: rtl/diff_block_pipe.sv
// Multi-lane residual stage (org - cur) with row framing for the SATD datapath.
// Optional block SAD accumulator is built only when DIFF_SAD_EN is defined.
module diff_block_pipe #(
    parameter int PIX_W = 8,
    parameter int LANES = 4,
    parameter int ROWS  = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             enable,
    input logic             clr,
    diff_block_pipe_if.slave bus
);
    localparam int DW    = PIX_W + 1;
    localparam int ROW_W = $clog2(ROWS);
    localparam int SAD_W = PIX_W + $clog2(LANES * ROWS);

    logic                  accept;
    logic                  row_is_last;
    logic [ROW_W-1:0]      row_q;
    logic                  out_valid_q;
    logic [LANES*DW-1:0]   diff_q;
    logic [LANES*DW-1:0]   diff_next;
    logic [ROW_W-1:0]      out_row_q;
    logic                  out_last_q;

    // A full output register may drain and refill in the same cycle.
    assign bus.in_ready = enable && !clr && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign row_is_last  = (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        diff_next = '0;
        for (int i = 0; i < LANES; i++) begin
            diff_next[i*DW +: DW] = {1'b0, bus.org[i*PIX_W +: PIX_W]}
                                  - {1'b0, bus.cur[i*PIX_W +: PIX_W]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            row_q       <= '0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
            row_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            diff_q      <= diff_next;
            out_row_q   <= row_q;
            out_last_q  <= row_is_last;
            row_q       <= row_is_last ? '0 : row_q + ROW_W'(1);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_last_q;

`ifdef DIFF_SAD_EN
    logic [SAD_W-1:0] acc_q;
    logic [SAD_W-1:0] acc_next;
    logic [SAD_W-1:0] sad_q;
    logic [SAD_W-1:0] lane_sum;
    logic [DW-1:0]    lane_d;
    logic [DW-1:0]    lane_neg;

    // Row 0 starts a fresh block sum; the final row's total is latched into sad.
    always_comb begin
        lane_sum = '0;
        lane_d   = '0;
        lane_neg = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_d   = diff_next[i*DW +: DW];
            lane_neg = -lane_d;
            lane_sum = lane_sum + SAD_W'(lane_d[PIX_W] ? lane_neg[PIX_W-1:0]
                                                       : lane_d[PIX_W-1:0]);
        end
        acc_next = ((row_q == '0) ? '0 : acc_q) + lane_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            sad_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_next;
            if (row_is_last) begin
                sad_q <= acc_next;
            end
        end
    end

    assign bus.sad = sad_q;
`else
    assign bus.sad = '0;
`endif
endmodule

// File: tb/tb_diff_block_pipe.sv
// Randomized self-checking bench for diff_block_pipe against a beat-level model.
// Build with or without DIFF_SAD_EN; the model follows the same macro.
module tb_diff_block_pipe;
    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int ROWS  = 4;

    logic clk;
    logic rst;
    logic enable;
    logic clr;

    int total;
    int bad;

    diff_block_pipe_if #(.PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS)) bus ();

    diff_block_pipe #(.PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clr    (clr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat-level model: residuals from integer subtraction, row = beats since restart mod ROWS.
    logic        m_valid;
    logic [35:0] m_diff;
    logic [1:0]  m_row;
    logic        m_last;
    logic [11:0] m_sad;
    int          m_beats;
    int          m_blk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid = 1'b0;
            m_diff  = '0;
            m_row   = '0;
            m_last  = 1'b0;
            m_sad   = '0;
            m_beats = 0;
            m_blk   = 0;
        end else if (clr) begin
            m_valid = 1'b0;
            m_beats = 0;
            m_blk   = 0;
        end else if (enable && bus.in_valid && (!m_valid || bus.out_ready)) begin
            int r;
            int s;
            r = m_beats % ROWS;
            s = 0;
            for (int i = 0; i < LANES; i++) begin
                int dv;
                dv = int'(bus.org[i*8 +: 8]) - int'(bus.cur[i*8 +: 8]);
                s  = s + ((dv < 0) ? -dv : dv);
                m_diff[i*9 +: 9] = dv[8:0];
            end
            m_blk = ((r == 0) ? 0 : m_blk) + s;
`ifdef DIFF_SAD_EN
            if (r == ROWS - 1) m_sad = 12'(m_blk);
`endif
            m_row   = 2'(r);
            m_last  = (r == ROWS - 1);
            m_valid = 1'b1;
            m_beats = m_beats + 1;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_ready;
        exp_ready = enable && !clr && (!m_valid || bus.out_ready);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("diff", 64'(bus.diff), 64'(m_diff));
            chk("out_row", 64'(bus.out_row), 64'(m_row));
            chk("out_last", 64'(bus.out_last), 64'(m_last));
        end
        chk("sad", 64'(bus.sad), 64'(m_sad));
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] o, input logic [31:0] c);
        bus.org       = o;
        bus.cur       = c;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
    endtask

    task automatic restart();
        bus.in_valid = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    int          rows_exp[5];
    logic        last_exp[5];
    logic [35:0] lit_diff;
    logic [11:0] lit_sad;

    initial begin
        total = 0;
        bad   = 0;
        rows_exp = '{0, 1, 2, 3, 0};
        last_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        lit_diff = {9'h0FF, 9'h101, 9'h064, 9'h1F6};
`ifdef DIFF_SAD_EN
        lit_sad = 12'd4080;
`else
        lit_sad = 12'd0;
`endif
        rst = 1'b0;
        enable = 1'b1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.org = '0;
        bus.cur = '0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset diff", 64'(bus.diff), 64'd0);
        chk("reset sad", 64'(bus.sad), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);

        // Mixed-sign lanes, then a 3-cycle downstream stall.
        beat({8'd255, 8'd0, 8'd200, 8'd10}, {8'd0, 8'd255, 8'd100, 8'd20});
        chk("lit diff", 64'(bus.diff), 64'(lit_diff));
        chk("lit row0", 64'(bus.out_row), 64'd0);
        bus.out_ready = 1'b0;
        bus.org = 32'h11223344;
        bus.cur = 32'h44332211;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall diff", 64'(bus.diff), 64'(lit_diff));
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("post-stall row", 64'(bus.out_row), 64'd1);

        restart();
        for (int k = 0; k < 5; k++) begin
            beat($urandom, $urandom);
            chk("b2b row", 64'(bus.out_row), 64'(rows_exp[k]));
            chk("b2b last", 64'(bus.out_last), 64'(last_exp[k]));
        end

        restart();
        for (int k = 0; k < 4; k++) beat(32'hFFFFFFFF, 32'h0);
        chk("max last", 64'(bus.out_last), 64'd1);
        chk("max sad", 64'(bus.sad), 64'(lit_sad));

        restart();
        beat($urandom, $urandom);
        beat($urandom, $urandom);
        restart();
        for (int k = 0; k < 4; k++) begin
            beat($urandom, $urandom);
            chk("clr last", 64'(bus.out_last), 64'(last_exp[k]));
        end

        beat($urandom, $urandom);
        beat($urandom, $urandom);
        rst = 1'b0;
        #1;
        chk("async out_valid", 64'(bus.out_valid), 64'd0);
        chk("async diff", 64'(bus.diff), 64'd0);
        chk("async sad", 64'(bus.sad), 64'd0);
        cyc();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            beat($urandom, $urandom);
            chk("rst row", 64'(bus.out_row), 64'(rows_exp[k]));
        end

        for (int k = 0; k < 3000; k++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            enable        = ($urandom_range(0, 7) != 0);
            clr           = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.org = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h0;
                bus.cur = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h0;
            end else begin
                bus.org = $urandom;
                bus.cur = $urandom;
            end
            cyc();
        end
        clr = 1'b0;
        enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
